// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses, register layouts, write masks,
// exception codes and small helpers used by the register file and its timer.
package cp0_regfile_pkg;

    // CP0 addresses are {rd[4:0], sel[2:0]}; every implemented register is sel 0.
    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};
    localparam logic [7:0] CP0_PRID     = {5'd15, 3'd0};
    localparam logic [7:0] CP0_CONFIG   = {5'd16, 3'd0};

    // Software-writable bits of Status (IM, EXL, IE) and Cause (IP[1:0]).
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Status comes out of reset with only BEV set.
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef struct packed {
        logic [8:0] rsvd_31_23;
        logic       bev;
        logic [5:0] rsvd_21_16;
        logic [7:0] im;
        logic [5:0] rsvd_7_2;
        logic       exl;
        logic       ie;
    } cp0_status_t;

    typedef struct packed {
        logic        bd;
        logic [14:0] rsvd_30_16;
        logic [7:0]  ip;
        logic        rsvd_7;
        logic [4:0]  exc_code;
        logic [1:0]  rsvd_1_0;
    } cp0_cause_t;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_IBE  = 5'd6,
        EXC_DBE  = 5'd7,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } cp0_exc_code_e;

    // Merge new data into the writable bits only; other bits keep their old value.
    function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // True when a commit lane carries an mtc0 aimed at the given register.
    function automatic logic lane_hit(input logic       we,
                                      input logic [7:0] wa,
                                      input logic [7:0] addr);
        return we && (wa == addr);
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Bundle between the commit stage and the CP0 register file.
// There is no backpressure: every strobe (cp0write, exc_valid, eret) is a
// single-cycle event that the register file always accepts at the next edge,
// and the outputs (rdata, epc, exl, int_req) are valid in every cycle.
interface cp0_regfile_if import cp0_regfile_pkg::*; ();

    logic [7:0]       cp0ra;
    logic [31:0]      rdata;
    logic [1:0]       cp0write;
    logic [1:0][7:0]  cp0wa;
    logic [1:0][31:0] wdata;
    logic             exc_valid;
    logic [4:0]       exc_code;
    logic [31:0]      exc_epc;
    logic             exc_bd;
    logic             exc_badv_we;
    logic [31:0]      exc_badvaddr;
    logic             eret;
    logic [5:0]       ext_int;
    logic [31:0]      epc;
    logic             exl;
    logic             int_req;

    // Commit side: drives writes, exception events and the read address.
    modport master (
        output cp0ra, cp0write, cp0wa, wdata,
        output exc_valid, exc_code, exc_epc, exc_bd, exc_badv_we, exc_badvaddr,
        output eret, ext_int,
        input  rdata, epc, exl, int_req
    );

    // Register-file side.
    modport slave (
        input  cp0ra, cp0write, cp0wa, wdata,
        input  exc_valid, exc_code, exc_epc, exc_bd, exc_badv_we, exc_badvaddr,
        input  eret, ext_int,
        output rdata, epc, exl, int_req
    );

endinterface

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: Count advances every COUNT_DIV cycles and TI latches
// when Count's next value equals Compare; a Compare write clears TI.
module cp0_timer
    import cp0_regfile_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we_i,
    input  logic [31:0] count_wdata_i,
    input  logic        compare_we_i,
    input  logic [31:0] compare_wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        phase_q, phase_d;
    logic        ti_q, ti_d;
    logic        inc;

    // Next-state: phase toggle, Count load/increment, Compare load, TI set/clear.
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        phase_d   = 1'b0;
        ti_d      = ti_q;
        inc       = 1'b1;

        // With a divide-by-two the phase bit gates every other increment.
        if (COUNT_DIV != 1) begin
            inc     = phase_q;
            phase_d = ~phase_q;
        end

        // A software load of Count restarts the divider and suppresses the increment.
        if (count_we_i) begin
            count_d = count_wdata_i;
            phase_d = 1'b0;
        end else if (inc) begin
            count_d = count_q + 32'd1;
        end

        if (compare_we_i) begin
            compare_d = compare_wdata_i;
        end

        // Clear from a Compare write beats a simultaneous match.
        if (compare_we_i) begin
            ti_d = 1'b0;
        end else if (count_d == compare_q) begin
            ti_d = 1'b1;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '0;
            phase_q   <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            phase_q   <= phase_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// Architectural CP0 register file: retires up to two mtc0 writes per cycle,
// applies ERET and exception-entry side effects, hosts the timer and raises
// the interrupt request. rdata is the committed value; forwarding of younger
// in-flight writes happens upstream.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] PRID      = 32'h0000_4220,
    parameter logic [31:0] CONFIG0   = 32'h8000_0000,
    parameter int          COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    cp0_regfile_if.slave bus
);

    cp0_status_t status_q, status_d;
    cp0_cause_t  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic        count_we;
    logic [31:0] count_wdata;
    logic        compare_we;
    logic [31:0] compare_wdata;
    logic [31:0] timer_count;
    logic [31:0] timer_compare;
    logic        timer_ti;

    // Decode Count/Compare strobes; iterating lane 0 then lane 1 lets the younger lane win.
    always_comb begin
        count_we      = 1'b0;
        count_wdata   = bus.wdata[0];
        compare_we    = 1'b0;
        compare_wdata = bus.wdata[0];
        for (int i = 0; i < 2; i++) begin
            if (lane_hit(bus.cp0write[i], bus.cp0wa[i], CP0_COUNT)) begin
                count_we    = 1'b1;
                count_wdata = bus.wdata[i];
            end
            if (lane_hit(bus.cp0write[i], bus.cp0wa[i], CP0_COMPARE)) begin
                compare_we    = 1'b1;
                compare_wdata = bus.wdata[i];
            end
        end
    end

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk             (clk),
        .reset           (reset),
        .count_we_i      (count_we),
        .count_wdata_i   (count_wdata),
        .compare_we_i    (compare_we),
        .compare_wdata_i (compare_wdata),
        .count_o         (timer_count),
        .compare_o       (timer_compare),
        .ti_o            (timer_ti)
    );

    // Next-state in retirement order: lane 0, lane 1, ERET, then exception entry on top.
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        for (int i = 0; i < 2; i++) begin
            if (lane_hit(bus.cp0write[i], bus.cp0wa[i], CP0_STATUS)) begin
                status_d = cp0_status_t'(apply_mask(status_d, bus.wdata[i], STATUS_WMASK));
            end
            if (lane_hit(bus.cp0write[i], bus.cp0wa[i], CP0_CAUSE)) begin
                cause_d = cp0_cause_t'(apply_mask(cause_d, bus.wdata[i], CAUSE_WMASK));
            end
            if (lane_hit(bus.cp0write[i], bus.cp0wa[i], CP0_EPC)) begin
                epc_d = bus.wdata[i];
            end
        end

        // Hardware pending bits are sampled every cycle; the timer shares IP7 with ext_int[5].
        cause_d.ip[7:2] = {bus.ext_int[5] | timer_ti, bus.ext_int[4:0]};

        if (bus.eret) begin
            status_d.exl = 1'b0;
        end

        // Exception entry is applied last so it overrides writes and ERET, even when EXL is already set.
        if (bus.exc_valid) begin
            status_d.exl     = 1'b1;
            cause_d.exc_code = bus.exc_code;
            cause_d.bd       = bus.exc_bd;
            epc_d            = bus.exc_epc;
            if (bus.exc_badv_we) begin
                badvaddr_d = bus.exc_badvaddr;
            end
        end
    end

    // Architectural register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q   <= cp0_status_t'(STATUS_RESET);
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Committed read port; unimplemented addresses and nonzero sel read as zero.
    always_comb begin
        bus.rdata = '0;
        case (bus.cp0ra)
            CP0_BADVADDR: bus.rdata = badvaddr_q;
            CP0_COUNT:    bus.rdata = timer_count;
            CP0_COMPARE:  bus.rdata = timer_compare;
            CP0_STATUS:   bus.rdata = status_q;
            CP0_CAUSE:    bus.rdata = cause_q;
            CP0_EPC:      bus.rdata = epc_q;
            CP0_PRID:     bus.rdata = PRID;
            CP0_CONFIG:   bus.rdata = CONFIG0;
            default:      bus.rdata = '0;
        endcase
    end

    assign bus.epc     = epc_q;
    assign bus.exl     = status_q.exl;
    assign bus.int_req = status_q.ie & ~status_q.exl & (|(cause_q.ip & status_q.im));

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: one instance with the divide-by-two timer,
// one with COUNT_DIV=1 for the wrap and clear-wins cases.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  localparam int SEL_RD0 = 0;
  localparam int SEL_RD1 = 1;
  localparam int SEL_EPC = 2;
  localparam int SEL_EXL = 3;
  localparam int SEL_INT = 4;

  logic clk;
  logic reset;

  cp0_regfile_if bus0 ();
  cp0_regfile_if bus1 ();

  cp0_regfile #(.PRID(32'h0000_4220), .CONFIG0(32'h8000_0000), .COUNT_DIV(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  cp0_regfile #(.PRID(32'h0000_4220), .CONFIG0(32'h8000_0000), .COUNT_DIV(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          total;
  int          bad;
  bit          done;

  logic [31:0] mon_exp;
  logic [31:0] mon_act;
  int          mon_sel;
  string       mon_name;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_sel  = sel_q.pop_front();
      mon_name = name_q.pop_front();
      case (mon_sel)
        SEL_RD0: mon_act = bus0.rdata;
        SEL_RD1: mon_act = bus1.rdata;
        SEL_EPC: mon_act = bus0.epc;
        SEL_EXL: mon_act = {31'd0, bus0.exl};
        default: mon_act = {31'd0, bus0.int_req};
      endcase
      total = total + 1;
      if (mon_act !== mon_exp) begin
        bad = bad + 1;
        $display("FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
      end
    end
  end

  // watchdog
  initial begin
    done = 1'b0;
    #200000;
    if (!done) begin
      bad = bad + 1;
      $display("FAIL watchdog: test did not finish in time");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // driver tasks
  task automatic idle();
    bus0.cp0write = 2'b00;  bus1.cp0write = 2'b00;
    bus0.exc_valid = 1'b0;  bus1.exc_valid = 1'b0;
    bus0.exc_badv_we = 1'b0; bus1.exc_badv_we = 1'b0;
    bus0.eret = 1'b0;       bus1.eret = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr0(input int lane, input logic [7:0] addr, input logic [31:0] data);
    bus0.cp0write[lane] = 1'b1;
    bus0.cp0wa[lane]    = addr;
    bus0.wdata[lane]    = data;
  endtask

  task automatic wr1(input int lane, input logic [7:0] addr, input logic [31:0] data);
    bus1.cp0write[lane] = 1'b1;
    bus1.cp0wa[lane]    = addr;
    bus1.wdata[lane]    = data;
  endtask

  task automatic expect_sig(input int sel, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  task automatic check_now(input logic [31:0] act, input logic [31:0] exp, input string nm);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rd0(input logic [7:0] addr, input logic [31:0] exp, input string nm);
    bus0.cp0ra = addr;
    expect_sig(SEL_RD0, exp, nm);
  endtask

  task automatic chk_rd1(input logic [7:0] addr, input logic [31:0] exp, input string nm);
    bus1.cp0ra = addr;
    expect_sig(SEL_RD1, exp, nm);
  endtask

  task automatic set_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic badv_we, input logic [31:0] badv);
    bus0.exc_valid    = 1'b1;
    bus0.exc_code     = code;
    bus0.exc_epc      = pc;
    bus0.exc_bd       = bd;
    bus0.exc_badv_we  = badv_we;
    bus0.exc_badvaddr = badv;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    bus0.cp0ra = '0; bus1.cp0ra = '0;
    bus0.cp0wa = '0; bus1.cp0wa = '0;
    bus0.wdata = '0; bus1.wdata = '0;
    bus0.exc_code = '0; bus0.exc_epc = '0; bus0.exc_bd = 1'b0; bus0.exc_badvaddr = '0;
    bus1.exc_code = '0; bus1.exc_epc = '0; bus1.exc_bd = 1'b0; bus1.exc_badvaddr = '0;
    bus0.ext_int = '0; bus1.ext_int = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // immediate reset-state checks
    check_now({31'd0, bus0.exl}, 32'd0, "now_reset_exl");
    check_now({31'd0, bus0.int_req}, 32'd0, "now_reset_int_req");
    check_now(bus0.epc, 32'd0, "now_reset_epc");
    bus0.cp0ra = CP0_STATUS;
    #1;
    check_now(bus0.rdata, 32'h0040_0000, "now_reset_status");

    // reset values and read-only / unimplemented addresses
    chk_rd0(CP0_STATUS, 32'h0040_0000, "reset_status");
    expect_sig(SEL_EPC, 32'd0, "reset_epc");
    expect_sig(SEL_EXL, 32'd0, "reset_exl");
    expect_sig(SEL_INT, 32'd0, "reset_int_req");
    tick();
    chk_rd0(CP0_PRID, 32'h0000_4220, "prid");
    tick();
    chk_rd0(8'h10, 32'd0, "unimpl_0x10");
    tick();
    chk_rd0(CP0_CONFIG, 32'h8000_0000, "config");
    wr0(0, 8'h61, 32'hFFFF_FFFF);
    wr0(1, CP0_PRID, 32'd0);
    tick();
    chk_rd0(8'h61, 32'd0, "status_sel1_reads_0");
    tick();
    chk_rd0(CP0_PRID, 32'h0000_4220, "prid_read_only");
    tick();
    chk_rd0(CP0_STATUS, 32'h0040_0000, "status_sel1_write_ignored");

    // dual-lane same-address write: lane 1 wins
    wr0(0, CP0_STATUS, 32'hFFFF_FFFF);
    wr0(1, CP0_STATUS, 32'h0000_0001);
    tick();
    chk_rd0(CP0_STATUS, 32'h0040_0001, "lane1_wins");

    // timer with divide-by-two; IE=1, IM7=1
    wr0(0, CP0_STATUS, 32'h0000_8001);
    tick();
    wr0(0, CP0_COUNT, 32'd0);
    wr0(1, CP0_COMPARE, 32'd4);
    tick();
    chk_rd0(CP0_COUNT, 32'd0, "count_loaded");
    tick();
    chk_rd0(CP0_COMPARE, 32'd4, "compare_loaded");
    repeat (6) tick();
    chk_rd0(CP0_COUNT, 32'd3, "count_after_7");
    tick();
    chk_rd0(CP0_COUNT, 32'd4, "count_after_8");
    expect_sig(SEL_INT, 32'd0, "int_req_before_ip7");
    tick();
    chk_rd0(CP0_CAUSE, 32'h0000_8000, "cause_ip7_timer");
    expect_sig(SEL_INT, 32'd1, "int_req_timer");
    wr0(0, CP0_COMPARE, 32'h0000_0100);
    tick();
    tick();
    chk_rd0(CP0_CAUSE, 32'd0, "cause_ip7_cleared");
    expect_sig(SEL_INT, 32'd0, "int_req_cleared");
    tick();

    // exception entry with EXL masking a pending external interrupt
    set_exc(5'd4, 32'hBFC0_0100, 1'b1, 1'b1, 32'h0000_1234);
    bus0.ext_int = 6'b100000;
    tick();
    expect_sig(SEL_EXL, 32'd1, "exc_exl");
    expect_sig(SEL_EPC, 32'hBFC0_0100, "exc_epc");
    expect_sig(SEL_INT, 32'd0, "exc_int_masked");
    chk_rd0(CP0_CAUSE, 32'h8000_8010, "exc_cause");
    tick();
    chk_rd0(CP0_BADVADDR, 32'h0000_1234, "exc_badvaddr");
    tick();
    chk_rd0(CP0_STATUS, 32'h0040_8003, "exc_status");
    bus0.eret = 1'b1;
    tick();
    expect_sig(SEL_EXL, 32'd0, "eret_exl");
    expect_sig(SEL_INT, 32'd1, "eret_int_unmasked");
    chk_rd0(CP0_STATUS, 32'h0040_8001, "eret_status");
    bus0.ext_int = 6'b000000;
    tick();
    expect_sig(SEL_INT, 32'd0, "ext_int_dropped");

    // exception + eret + EPC write in one cycle: exception wins
    set_exc(5'd8, 32'h8000_0180, 1'b0, 1'b0, 32'hFFFF_FFFF);
    bus0.eret = 1'b1;
    wr0(0, CP0_EPC, 32'hDEAD_0000);
    tick();
    expect_sig(SEL_EXL, 32'd1, "exc_eret_exl");
    expect_sig(SEL_EPC, 32'h8000_0180, "exc_over_epc_write");
    chk_rd0(CP0_CAUSE, 32'h0000_0020, "exc_sys_cause");
    tick();
    chk_rd0(CP0_BADVADDR, 32'h0000_1234, "badv_hold");
    bus0.eret = 1'b1;
    tick();
    expect_sig(SEL_EXL, 32'd0, "eret2_exl");
    wr0(0, CP0_CAUSE, 32'hFFFF_FFFF);
    tick();
    chk_rd0(CP0_CAUSE, 32'h0000_0320, "cause_write_mask");
    expect_sig(SEL_INT, 32'd0, "sw_ip_not_enabled");
    wr0(0, CP0_STATUS, 32'h0000_0301);
    tick();
    chk_rd0(CP0_STATUS, 32'h0040_0301, "status_im_sw");
    expect_sig(SEL_INT, 32'd1, "int_req_sw_ip");
    wr0(1, CP0_EPC, 32'h1234_5678);
    tick();
    expect_sig(SEL_EPC, 32'h1234_5678, "epc_write");

    // COUNT_DIV=1: wrap to zero matches Compare=0
    wr1(0, CP0_COUNT, 32'hFFFF_FFFF);
    wr1(1, CP0_COMPARE, 32'd0);
    tick();
    chk_rd1(CP0_COUNT, 32'hFFFF_FFFF, "div1_count_loaded");
    tick();
    chk_rd1(CP0_COUNT, 32'd0, "div1_count_wrap");
    tick();
    chk_rd1(CP0_CAUSE, 32'h0000_8000, "div1_wrap_ti");

    // reset mid-operation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_rd0(CP0_STATUS, 32'h0040_0000, "rst2_status");
    expect_sig(SEL_EPC, 32'd0, "rst2_epc");
    expect_sig(SEL_EXL, 32'd0, "rst2_exl");
    expect_sig(SEL_INT, 32'd0, "rst2_int_req");
    chk_rd1(CP0_CAUSE, 32'd0, "rst2_cause_div1");
    tick();
    chk_rd1(CP0_CAUSE, 32'd0, "rst2_ti_discarded");
    chk_rd0(CP0_BADVADDR, 32'd0, "rst2_badvaddr");

    // COUNT_DIV=1: Compare write in the matching cycle keeps TI clear
    wr1(0, CP0_COMPARE, 32'd5);
    wr1(1, CP0_COUNT, 32'd3);
    tick();
    chk_rd1(CP0_COUNT, 32'd3, "clrwin_count3");
    tick();
    chk_rd1(CP0_COUNT, 32'd4, "clrwin_count4");
    wr1(0, CP0_COMPARE, 32'h0000_0050);
    tick();
    tick();
    chk_rd1(CP0_CAUSE, 32'd0, "clear_wins_over_match");
    tick();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad = bad + exp_q.size();
      $display("FAIL scoreboard: %0d expectations never compared", exp_q.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else          $display("FAIL");
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Architectural CP0 register file: the write end of the CP0 forwarding path.
- Retires up to two mtc0 writes per cycle from the commit stage (lane 0 older) and applies exception entry and ERET side effects.
- Runs the Count/Compare timer and raises the interrupt request.
- Provides the committed (non-forwarded) read value; the upstream CP0 bypass overrides it when a younger in-flight write matches.

Parameters:
- PRID, 32'h0000_4220, read-only value of PRId (rd 15, sel 0).
- CONFIG0, 32'h8000_0000, read-only value of Config (rd 16, sel 0).
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles; legal values 1 or 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cp0ra  in  8  read address {rd[4:0], sel[2:0]}
- rdata  out  32  combinational read of the committed register value
- cp0write  in  2  per-lane write enable; lane 0 is older
- cp0wa  in  2x8  per-lane write address, same encoding as cp0ra
- wdata  in  2x32  per-lane write data
- exc_valid  in  1  exception taken this cycle
- exc_code  in  5  Cause.ExcCode value
- exc_epc  in  32  PC of the faulting instruction (already adjusted for delay slot)
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_badv_we  in  1  update BadVAddr
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET retiring this cycle
- ext_int  in  6  hardware interrupt lines, level-sensitive
- epc  out  32  current EPC
- exl  out  1  Status.EXL
- int_req  out  1  Status.IE & ~Status.EXL & |(Cause.IP & Status.IM)

Behaviour:
- Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15), Config(16), all sel 0.
- Any other address, or sel != 0, reads 0; writes to it are ignored.
- Reset values:
  - Status = 32'h0040_0000 (BEV=1).
  - Count, Compare, Cause, EPC, BadVAddr = 0.
  - Timer phase = 0.
  - Outputs epc=0, exl=0, int_req=0.
- Write masks:
  - Status: 32'h0000_FF03 (IM[7:0], EXL, IE).
  - Cause: 32'h0000_0300 (IP[1:0]).
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr, PRId, Config: read-only.
- All updates take effect at the clock edge. rdata reflects them the next cycle; there is no internal write-to-read bypass.
- Same-cycle ordering, applied in sequence:
  1. Lane 0 write.
  2. Lane 1 write (lane 1 wins on same address).
  3. ERET clears EXL.
  4. Exception entry: EXL=1; Cause.ExcCode=exc_code; Cause.BD=exc_bd; EPC=exc_epc; if exc_badv_we, BadVAddr=exc_badvaddr.
  - An exception overrides any same-cycle write to the same fields.
  - exc_valid together with eret: the exception wins and EXL ends at 1.
  - Exception entry while EXL=1 still updates all fields.
- Timer:
  - Phase bit toggles every cycle when COUNT_DIV=2.
  - Count increments (modulo 2^32, wraps silently) on cycles where phase=1, or every cycle when COUNT_DIV=1.
  - An mtc0 to Count loads wdata and clears phase; no increment that cycle.
  - TI is set on the cycle after Count's next value equals Compare.
  - An mtc0 to Compare clears TI. It does not set TI, even if Count already equals the new value.
  - When a Compare write and a match occur in the same cycle, clear wins.
- Cause.IP[7:2] is registered each cycle as {ext_int[5] | TI, ext_int[4:0]}. int_req is therefore one cycle after ext_int changes.
- Reset mid-operation restores all reset values on the next edge; a pending TI is discarded.

Decomposition:
- Shared package contents:
  - CP0 address constants (CP0_COUNT = {5'd9, 3'd0}, etc.).
  - cp0_status_t and cp0_cause_t packed structs.
  - Write-mask constants.
  - Exception-code enum.
- One natural sub-module, cp0_timer: owns Count, Compare, phase and TI; takes the decoded Count/Compare write strobes.

Test Plan:
- Reset, then read 8'h60 (Status) -> 32'h0040_0000; read 8'h78 (PRId) -> 32'h0000_4220; read 8'h10 -> 0.
- Same cycle: lane 0 writes Status 32'hFFFF_FFFF, lane 1 writes Status 32'h0000_0001 -> next-cycle Status = 32'h0040_0001.
- Write Count=0, Compare=4 with COUNT_DIV=2 -> Count reaches 4 after 8 cycles; TI and Cause[15] set one cycle later. With IE=1, IM7=1 -> int_req=1. A Compare write -> TI=0, int_req=0 next cycle.
- exc_valid with code 5'd4, epc 32'hBFC0_0100, bd=1, badv 32'h1234 -> EXL=1, Cause.ExcCode=4, BD=1, EPC and BadVAddr updated, int_req forced 0. Then eret -> EXL=0.
- exc_valid and eret in the same cycle, plus a lane-0 write of EPC=32'hDEAD_0000 -> EXL=1, EPC=exc_epc.
- Count=32'hFFFF_FFFF, COUNT_DIV=1 -> wraps to 0 next cycle; with Compare=0, TI sets.
